// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_t;

    // Digits at or above this value get +3 before each shift
    localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

    // 10^n, used to derive the largest representable magnitude
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake plus result bundle between the ALU side and the converter.
interface bin2bcd_seq_if #(
    parameter int unsigned W = 8
) ();
    import bcd_pkg::*;

    logic         start;
    logic [W-1:0] value;
    logic         busy;
    logic         done;
    bcd_digit_t   units;
    bcd_digit_t   tens;
    bcd_digit_t   hundreds;
    logic         neg;
    logic         ovf;

    modport master (
        output start, value,
        input  busy, done, units, tens, hundreds, neg, ovf
    );

    modport slave (
        input  start, value,
        output busy, done, units, tens, hundreds, neg, ovf
    );

endinterface

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t corrected
);

    assign corrected = (digit >= BCD_ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Define BIN2BCD_SIGNED_EN to treat value as two's complement; otherwise it is
// unsigned and neg is tied low.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned NDIG = 3
) (
    input logic          clk,
    input logic          reset,
    bin2bcd_seq_if.slave bus
);

    localparam int unsigned BCDW    = 4 * NDIG;
    localparam int unsigned CNTW    = $clog2(W + 1);
    localparam int unsigned MAX_MAG = pow10(NDIG) - 1;

    b2b_state_t      state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [BCDW-1:0] bcd_q, bcd_d, bcd_fix;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [W:0]      mag;
    logic [BCDW-1:0] digits_q;
    logic            ovf_out_q;
    logic            done_q;

    // Magnitude is W+1 bits wide so that -2^(W-1) negates exactly
`ifdef BIN2BCD_SIGNED_EN
    logic       mag_sign;
    logic [W:0] value_ext;
    logic       sign_q;
    logic       neg_q;

    assign mag_sign  = bus.value[W-1];
    assign value_ext = {bus.value[W-1], bus.value};
    assign mag       = mag_sign ? -value_ext : value_ext;

    // Capture sign at start, publish it with the digits in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) sign_q <= mag_sign;
            if (state_q == DONE) neg_q <= sign_q;
        end
    end

    assign bus.neg = neg_q;
`else
    assign mag     = {1'b0, bus.value};
    assign bus.neg = 1'b0;
`endif

    for (genvar i = 0; i < NDIG; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit    (bcd_q[4*i +: 4]),
            .corrected(bcd_fix[4*i +: 4])
        );
    end

    // FSM, shift register and counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: load on start, W correct-and-shift steps, then one DONE cycle
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d   = mag[W-1:0];
                    bcd_d   = '0;
                    cnt_d   = CNTW'(W);
                    ovf_d   = 32'(mag) > MAX_MAG;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_fix, bin_q} << 1;
                cnt_d          = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result registers only change in DONE; done pulses alongside them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q  <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                digits_q  <= bcd_q;
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_out_q;
    assign bus.units = digits_q[3:0];
    assign bus.tens  = digits_q[7:4];

    if (NDIG >= 3) begin : g_hundreds
        assign bus.hundreds = digits_q[11:8];
    end else begin : g_no_hundreds
        assign bus.hundreds = '0;
    end

endmodule
